// File: rtl/u_sequencer.sv
// rtl/u_sequencer.sv - microsequencer: MPC/MIR registers, LOAD/EXEC/HALT FSM, next-address logic
// Optional cycle counter port enabled by USEQ_UCYCLE_COUNTER_EN.
module u_sequencer #(
  parameter int MIR_BUS_WIDTH       = 41,
  parameter int Direction_BUS_WIDTH = 11,
  parameter logic [Direction_BUS_WIDTH-1:0] START_ADDR = 11'h000,
  parameter logic [Direction_BUS_WIDTH-1:0] HALT_ADDR  = 11'h7FF,
  parameter int JAM_BIT             = 8
) (
  input  logic                           uSequencer_CLOCK_50,
  input  logic                           uSequencer_RESET_InHigh,
  input  logic                           uSequencer_Start_IN,
  input  logic                           uSequencer_Stall_IN,
  input  logic                           uSequencer_FlagN_IN,
  input  logic                           uSequencer_FlagZ_IN,
  input  logic [7:0]                     uSequencer_MBR_IN,
  input  logic [MIR_BUS_WIDTH-1:0]       ROM_Microinstruccion_IN,
  output logic [Direction_BUS_WIDTH-1:0] ROM_Direccion_OUT,
  output logic [26:0]                    uSequencer_MIR_OUT,
  output logic                           uSequencer_MIRValid_OUT,
  output logic                           uSequencer_Halted_OUT
`ifdef USEQ_UCYCLE_COUNTER_EN
  ,
  output logic [31:0]                    uSequencer_UCount_OUT
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_EXEC = 2'd2;
  localparam logic [1:0] S_HALT = 2'd3;

  logic [1:0]                     state_q, state_d;
  logic [Direction_BUS_WIDTH-1:0] mpc_q, mpc_d;
  logic [MIR_BUS_WIDTH-1:0]       mir_q, mir_d;
  logic [Direction_BUS_WIDTH-1:0] next_addr;

  // MIR fields: [40:30] NEXT_ADDR, [29] JMPC, [28] JAMN, [27] JAMZ
  always_comb begin
    next_addr = mir_q[MIR_BUS_WIDTH-1 -: Direction_BUS_WIDTH];
    if ((mir_q[28] & uSequencer_FlagN_IN) | (mir_q[27] & uSequencer_FlagZ_IN))
      next_addr[JAM_BIT] = 1'b1;
    if (mir_q[29])
      next_addr[7:0] = next_addr[7:0] | uSequencer_MBR_IN;
  end

  always_comb begin
    state_d = state_q;
    mpc_d   = mpc_q;
    mir_d   = mir_q;
    case (state_q)
      S_IDLE, S_HALT: begin
        if (uSequencer_Start_IN) begin
          state_d = S_LOAD;
          mpc_d   = START_ADDR;
        end
      end
      S_LOAD: begin
        mir_d   = ROM_Microinstruccion_IN;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        if (!uSequencer_Stall_IN) begin
          mpc_d   = next_addr;
          state_d = (next_addr == HALT_ADDR) ? S_HALT : S_LOAD;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge uSequencer_CLOCK_50 or posedge uSequencer_RESET_InHigh) begin
    if (uSequencer_RESET_InHigh) begin
      state_q <= S_IDLE;
      mpc_q   <= START_ADDR;
      mir_q   <= '0;
    end else begin
      state_q <= state_d;
      mpc_q   <= mpc_d;
      mir_q   <= mir_d;
    end
  end

  assign ROM_Direccion_OUT       = mpc_q;
  assign uSequencer_MIR_OUT      = mir_q[26:0];
  assign uSequencer_MIRValid_OUT = (state_q == S_EXEC);
  assign uSequencer_Halted_OUT   = (state_q == S_HALT);

`ifdef USEQ_UCYCLE_COUNTER_EN
  logic [31:0] ucount_q, ucount_d;

  always_comb begin
    ucount_d = ucount_q;
    if (((state_q == S_IDLE) || (state_q == S_HALT)) && uSequencer_Start_IN)
      ucount_d = 32'd0;
    else if ((state_q == S_EXEC) && !uSequencer_Stall_IN)
      ucount_d = ucount_q + 32'd1;
  end

  always_ff @(posedge uSequencer_CLOCK_50 or posedge uSequencer_RESET_InHigh) begin
    if (uSequencer_RESET_InHigh) ucount_q <= 32'd0;
    else                         ucount_q <= ucount_d;
  end

  assign uSequencer_UCount_OUT = ucount_q;
`endif

endmodule

// File: tb/tb_u_sequencer.sv
// tb/tb_u_sequencer.sv - self-checking bench for u_sequencer with directed microprogram
module tb_u_sequencer;

  logic        clk, rst, start, stall, fn, fz;
  logic [7:0]  mbr;
  logic [40:0] rom_data;
  logic [10:0] rom_addr;
  logic [26:0] mir_o;
  logic        valid, halted;
`ifdef USEQ_UCYCLE_COUNTER_EN
  logic [31:0] ucount;
`endif

  logic [40:0] rom [0:2047];
  int checks = 0;
  int fails  = 0;

  assign rom_data = rom[rom_addr];

  u_sequencer dut (
    .uSequencer_CLOCK_50     (clk),
    .uSequencer_RESET_InHigh (rst),
    .uSequencer_Start_IN     (start),
    .uSequencer_Stall_IN     (stall),
    .uSequencer_FlagN_IN     (fn),
    .uSequencer_FlagZ_IN     (fz),
    .uSequencer_MBR_IN       (mbr),
    .ROM_Microinstruccion_IN (rom_data),
    .ROM_Direccion_OUT       (rom_addr),
    .uSequencer_MIR_OUT      (mir_o),
    .uSequencer_MIRValid_OUT (valid),
    .uSequencer_Halted_OUT   (halted)
`ifdef USEQ_UCYCLE_COUNTER_EN
    ,
    .uSequencer_UCount_OUT   (ucount)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [40:0] mk(input logic [10:0] nxt, input logic jmpc, input logic jamn,
                                     input logic jamz, input logic [10:0] tag);
    return {nxt, jmpc, jamn, jamz, 16'hA5C3, tag};
  endfunction

  // Next address from the plain rule: NEXT, OR 0x100 on a taken jam, OR MBR on JMPC
  function automatic logic [10:0] na_of(input logic [40:0] w, input logic n, input logic z,
                                        input logic [7:0] b);
    int a;
    a = int'(w[40:30]);
    if ((w[28] && n) || (w[27] && z)) a = a | 256;
    if (w[29]) a = a | int'(b);
    return 11'(a & 'h7FF);
  endfunction

  // Model: phase 0 idle, 1 fetch, 2 execute, 3 halted
  int          m_mode;
  logic [10:0] m_pc;
  logic [40:0] m_ir;
  logic [31:0] m_cnt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode <= 0; m_pc <= 11'h000; m_ir <= '0; m_cnt <= 32'd0;
    end else if (m_mode == 1) begin
      m_ir <= rom[m_pc]; m_mode <= 2;
    end else if (m_mode == 2) begin
      if (!stall) begin
        m_cnt  <= m_cnt + 32'd1;
        m_pc   <= na_of(m_ir, fn, fz, mbr);
        m_mode <= (na_of(m_ir, fn, fz, mbr) == 11'h7FF) ? 3 : 1;
      end
    end else if (start) begin
      m_mode <= 1; m_pc <= 11'h000; m_cnt <= 32'd0;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("cmp_addr",   32'(rom_addr), 32'(m_pc));
      chk("cmp_mir",    32'(mir_o),    32'(m_ir[26:0]));
      chk("cmp_valid",  32'(valid),    32'(m_mode == 2));
      chk("cmp_halted", 32'(halted),   32'(m_mode == 3));
`ifdef USEQ_UCYCLE_COUNTER_EN
      chk("cmp_ucount", ucount, m_cnt);
`endif
    end
  end

  task automatic step(input logic [10:0] exp_addr, input logic n, input logic z,
                      input logic [7:0] b, input int stalls);
    int i;
    i = 0;
    while (m_mode != 1 && i < 20) begin
      @(negedge clk);
      i++;
    end
    chk("load_reached", 32'(i < 20), 32'd1);
    chk("load_addr", 32'(rom_addr), 32'(exp_addr));
    fn = n; fz = z; mbr = b; stall = (stalls > 0);
    @(negedge clk);
    if (stalls > 0) begin
      repeat (stalls) @(negedge clk);
      stall = 1'b0;
    end
  endtask

  initial begin
    for (int a = 0; a < 2048; a++) rom[a] = '0;
    rom[11'h000] = mk(11'h005, 1'b0, 1'b0, 1'b0, 11'h000);
    rom[11'h005] = mk(11'h010, 1'b0, 1'b0, 1'b1, 11'h005);
    rom[11'h110] = mk(11'h010, 1'b0, 1'b0, 1'b1, 11'h110);
    rom[11'h010] = mk(11'h000, 1'b1, 1'b1, 1'b0, 11'h010);
    rom[11'h13C] = mk(11'h000, 1'b1, 1'b0, 1'b0, 11'h13C);
    rom[11'h03C] = mk(11'h7FF, 1'b0, 1'b0, 1'b0, 11'h03C);

    rst = 1'b0; start = 1'b0; stall = 1'b0; fn = 1'b0; fz = 1'b0; mbr = 8'h00;
    #1 rst = 1'b1;
    #2;
    chk("rst_addr",   32'(rom_addr), 32'h000);
    chk("rst_mir",    32'(mir_o),    32'h0);
    chk("rst_valid",  32'(valid),    32'd0);
    chk("rst_halted", 32'(halted),   32'd0);
`ifdef USEQ_UCYCLE_COUNTER_EN
    chk("rst_ucount", ucount, 32'd0);
`endif
    #9 rst = 1'b0;

    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    step(11'h000, 1'b0, 1'b0, 8'h00, 0);
    step(11'h005, 1'b0, 1'b1, 8'h00, 0);
    step(11'h110, 1'b0, 1'b0, 8'h00, 0);
    step(11'h010, 1'b1, 1'b0, 8'h3C, 0);
    step(11'h13C, 1'b1, 1'b0, 8'h3C, 0);
    step(11'h03C, 1'b0, 1'b0, 8'h00, 3);

    @(negedge clk);
    chk("halt_flag",  32'(halted),   32'd1);
    chk("halt_valid", 32'(valid),    32'd0);
    chk("halt_addr",  32'(rom_addr), 32'h7FF);
`ifdef USEQ_UCYCLE_COUNTER_EN
    chk("halt_ucount", ucount, 32'd6);
`endif
    repeat (2) @(negedge clk);
    chk("halt_hold", 32'(halted), 32'd1);
    start = 1'b1; stall = 1'b1;
    @(negedge clk);
    start = 1'b0; stall = 1'b0;
    chk("restart_addr",   32'(rom_addr), 32'h000);
    chk("restart_halted", 32'(halted),   32'd0);
    chk("restart_valid",  32'(valid),    32'd0);
`ifdef USEQ_UCYCLE_COUNTER_EN
    chk("restart_ucount", ucount, 32'd0);
`endif

    stall = 1'b1;
    @(negedge clk);
    chk("stall_valid", 32'(valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mrst_addr",   32'(rom_addr), 32'h000);
    chk("mrst_mir",    32'(mir_o),    32'h0);
    chk("mrst_valid",  32'(valid),    32'd0);
    chk("mrst_halted", 32'(halted),   32'd0);
`ifdef USEQ_UCYCLE_COUNTER_EN
    chk("mrst_ucount", ucount, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0; stall = 1'b0;

    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    step(11'h000, 1'b0, 1'b0, 8'h00, 0);
    step(11'h005, 1'b0, 1'b0, 8'h00, 0);
    step(11'h010, 1'b0, 1'b0, 8'h00, 0);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
